sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo_if.sv | 28 ++
 rtl/sync_fifo.sv | 76 +++++++
 tb/tb_sync_fifo.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_if.sv
// Write/read handshake and status bundle for sync_fifo.
// master = the FIFO user, slave = the FIFO itself.
interface sync_fifo_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   level;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, full, empty, almost_full, almost_empty, level, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, full, empty, almost_full, almost_empty, level, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit binary pointers, threshold flags,
// error pulses and selectable registered or first-word-fall-through read.
module sync_fifo #(
    parameter int DATA_WIDTH    = 16,
    parameter int FIFO_DEPTH    = 8,
    parameter int ADDR_WIDTH    = 3,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = 0
) (
    input logic       clk,
    input logic       rst,
    sync_fifo_if.slave fif
);
    localparam logic [ADDR_WIDTH:0] AFULL_LVL  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0] PTR_ONE    = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   level;
    logic                  full;
    logic                  empty;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  ovf_q;
    logic                  unf_q;

    // Accept decisions use pre-edge flags; reset blocks any memory write too.
    always_comb begin
        level  = wr_ptr - rd_ptr;
        empty  = (wr_ptr == rd_ptr);
        full   = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                 (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
        wr_acc = fif.wr_en & ~full & ~rst;
        rd_acc = fif.rd_en & ~empty;
        head   = mem[rd_ptr[ADDR_WIDTH-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rd_q   <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                rd_q   <= head;
            end
            ovf_q <= fif.wr_en & full;
            unf_q <= fif.rd_en & empty;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr[ADDR_WIDTH-1:0]] <= fif.wr_data;
    end

    always_comb begin
        fif.full         = full;
        fif.empty        = empty;
        fif.level        = level;
        fif.almost_full  = (level >= AFULL_LVL);
        fif.almost_empty = (level <= AEMPTY_LVL);
        fif.overflow     = ovf_q;
        fif.underflow    = unf_q;
        if (FWFT != 0) fif.rd_data = empty ? '0 : head;
        else           fif.rd_data = rd_q;
    end
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: stimulus pushes expected read words into a
// scoreboard queue, a separate monitor pops and compares registered read data.
module tb_sync_fifo;
    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) f0 ();
    sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) f1 ();

    sync_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW),
                .AFULL_THRESH(6), .AEMPTY_THRESH(2), .FWFT(0))
        dut0 (.clk(clk), .rst(rst), .fif(f0));

    sync_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW),
                .AFULL_THRESH(6), .AEMPTY_THRESH(2), .FWFT(1))
        dut1 (.clk(clk), .rst(rst), .fif(f1));

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] mq[$];     // expected FIFO contents
    logic [DW-1:0] exp_q[$];  // expected words for the read monitor
    bit            rd_pending = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of FWFT=0 stimulus, then check status against the model.
    task automatic step(input bit w, input logic [DW-1:0] d, input bit r);
        bit wacc;
        bit racc;
        int n;
        n    = mq.size();
        wacc = w && (n < DEPTH);
        racc = r && (n > 0);
        f0.wr_en   = w;
        f0.wr_data = d;
        f0.rd_en   = r;
        rd_pending = racc;
        if (racc) exp_q.push_back(mq.pop_front());
        if (wacc) mq.push_back(d);
        @(posedge clk); #1;
        f0.wr_en   = 1'b0;
        f0.rd_en   = 1'b0;
        rd_pending = 1'b0;
        n = mq.size();
        chk("level",        32'(f0.level),        32'(n));
        chk("full",         32'(f0.full),         32'(n == DEPTH));
        chk("empty",        32'(f0.empty),        32'(n == 0));
        chk("almost_full",  32'(f0.almost_full),  32'(n >= 6));
        chk("almost_empty", 32'(f0.almost_empty), 32'(n <= 2));
        chk("overflow",     32'(f0.overflow),     32'(w && !wacc));
        chk("underflow",    32'(f0.underflow),    32'(r && !racc));
    endtask

    // Read monitor: a read accepted at an edge must show its word by the next negedge.
    initial begin
        bit fire;
        forever begin
            @(posedge clk);
            fire = rd_pending;
            @(negedge clk);
            if (fire) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rd_data: got %0h with no expected word queued", f0.rd_data);
                end else begin
                    chk("rd_data", 32'(f0.rd_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        f0.wr_en = 1'b0; f0.wr_data = '0; f0.rd_en = 1'b0;
        f1.wr_en = 1'b0; f1.wr_data = '0; f1.rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_level",  32'(f0.level),        32'd0);
        chk("rst_empty",  32'(f0.empty),        32'd1);
        chk("rst_full",   32'(f0.full),         32'd0);
        chk("rst_aempty", 32'(f0.almost_empty), 32'd1);
        chk("rst_afull",  32'(f0.almost_full),  32'd0);
        chk("rst_ovf",    32'(f0.overflow),     32'd0);
        chk("rst_unf",    32'(f0.underflow),    32'd0);
        chk("rst_rdata",  32'(f0.rd_data),      32'd0);
        chk("rst_rdata1", 32'(f1.rd_data),      32'd0);

        // Fill with 1..8, then one write too many
        for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0);
        chk("fill_level", 32'(f0.level), 32'd8);
        chk("fill_full",  32'(f0.full),  32'd1);
        step(1'b1, 16'h0009, 1'b0);
        chk("ovf_pulse",  32'(f0.overflow), 32'd1);
        chk("ovf_level",  32'(f0.level),    32'd8);
        step(1'b0, '0, 1'b0);
        chk("ovf_clear",  32'(f0.overflow), 32'd0);

        // Drain 8, then one read too many: data must hold the last word
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
        chk("drain_empty", 32'(f0.empty), 32'd1);
        step(1'b0, '0, 1'b1);
        chk("unf_pulse", 32'(f0.underflow), 32'd1);
        chk("unf_hold",  32'(f0.rd_data),   32'h0008);
        step(1'b0, '0, 1'b0);
        chk("unf_clear", 32'(f0.underflow), 32'd0);

        // Full with simultaneous read/write: read wins, write rejected
        for (int i = 0; i < 8; i++) step(1'b1, DW'(16'h0010 + i), 1'b0);
        step(1'b1, 16'h0099, 1'b1);
        chk("fullrw_level", 32'(f0.level),    32'd7);
        chk("fullrw_ovf",   32'(f0.overflow), 32'd1);

        // Down to level 4, then 20 simultaneous cycles across pointer wraps
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, DW'(16'h0100 + i), 1'b1);
            chk("rw_level4", 32'(f0.level), 32'd4);
        end
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        // Mid-operation reset at level 5 with a write pending
        for (int i = 0; i < 5; i++) step(1'b1, DW'(16'h0050 + i), 1'b0);
        f0.wr_en = 1'b1; f0.wr_data = 16'hDEAD; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; f0.wr_en = 1'b0;
        mq.delete();
        chk("mrst_level", 32'(f0.level),     32'd0);
        chk("mrst_empty", 32'(f0.empty),     32'd1);
        chk("mrst_ovf",   32'(f0.overflow),  32'd0);
        chk("mrst_unf",   32'(f0.underflow), 32'd0);
        step(1'b1, 16'h0777, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        chk("mrst_rdata", 32'(f0.rd_data), 32'h0777);

        // FWFT instance: word falls through with no rd_en
        f1.wr_en = 1'b1; f1.wr_data = 16'hABCD;
        @(posedge clk); #1;
        f1.wr_en = 1'b0;
        chk("fwft_data",  32'(f1.rd_data), 32'hABCD);
        chk("fwft_empty", 32'(f1.empty),   32'd0);
        @(posedge clk); #1;
        chk("fwft_hold",  32'(f1.rd_data), 32'hABCD);
        f1.rd_en = 1'b1;
        @(posedge clk); #1;
        f1.rd_en = 1'b0;
        chk("fwft_pop_empty", 32'(f1.empty),   32'd1);
        chk("fwft_pop_data",  32'(f1.rd_data), 32'd0);

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
